sdram_arbiter: RTL and testbench

Shares the single 32-bit SDRAM controller port between the ROM segment requesters (program, text, fg, bg, sprite, sound) and the IOCTL download path. Port 0 (program ROM) gets fixed priority, bounded by a starvation limit. Ports 1..N-1 are served round-robin. The block tracks outstanding reads in an in-order grant FIFO and routes `sdram_ack` and `sdram_valid` back to the correct requester. It sits between the ROM segment instances and the SDRAM controller, replacing the ad-hoc priority mux.

---
 rtl/rom_ctrl_pkg.sv | 21 ++
 rtl/sdram_arbiter_grant_fifo.sv | 57 +++++
 rtl/sdram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
`timescale 1ns/1ps
// rom_ctrl_pkg
// Shared definitions for the ROM/SDRAM arbitration slice:
//   state_e      - arbiter FSM states (IDLE, ISSUE, DL)
//   PORT_*       - requester index of each ROM segment on the arbiter
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DL    = 2'd2
  } state_e;

  localparam int PORT_PROG   = 0;
  localparam int PORT_TEXT   = 1;
  localparam int PORT_FG     = 2;
  localparam int PORT_BG     = 3;
  localparam int PORT_SPRITE = 4;
  localparam int PORT_SOUND  = 5;

endpackage

// File: rtl/sdram_arbiter_grant_fifo.sv
`timescale 1ns/1ps
// grant_fifo
// In-order record of which requester owns each outstanding SDRAM read.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset (clears pointers)
//   push_i, data_i  - append a requester index
//   pop_i           - drop the oldest entry
//   empty_o, full_o - occupancy flags
//   head_o          - oldest entry, readable in the same cycle as pop_i
module grant_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   rd_q, rd_d;

  always_comb begin
    wr_d = push_i ? wr_q + (PTR_W+1)'(1) : wr_q;
    rd_d = pop_i  ? rd_q + (PTR_W+1)'(1) : rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PTR_W-1:0]] <= data_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  // Combinational head so the data-valid pulse can be routed in its own cycle.
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
// sdram_arbiter
// Shares the single SDRAM controller port between the ROM requesters and the
// IOCTL download path. Port 0 has priority (bounded by STARVE_MAX), ports
// 1..N-1 are served round-robin; read returns are routed in grant order.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   port_req/port_addr         - per-requester read request and flat addresses
//   port_ack/port_valid        - per-requester accept / data-valid pulses
//   download*                  - IOCTL download pass-through inputs
//   sdram_addr/data/we/req     - request side towards the SDRAM controller
//   sdram_ack/sdram_valid      - controller accept and read-data-valid
//   err_orphan                 - sticky: read data arrived with nothing pending
module sdram_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int NUM_PORTS   = 6,
  parameter int ADDR_WIDTH  = 23,
  parameter int MAX_PENDING = 4,
  parameter int STARVE_MAX  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  output logic [NUM_PORTS-1:0]            port_ack,
  output logic [NUM_PORTS-1:0]            port_valid,
  input  logic                            download,
  input  logic                            download_req,
  input  logic                            download_we,
  input  logic [ADDR_WIDTH-1:0]           download_addr,
  input  logic [31:0]                     download_data,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [31:0]                     sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  output logic                            err_orphan
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  err_orphan_q, err_orphan_d;

  logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [IDX_W-1:0]      fifo_head;
  logic                  others_req, p0_wins, take;
  logic [IDX_W-1:0]      winner;

  // First requesting port among 1..N-1 starting at ptr, wrapping N-1 -> 1.
  // The sum is one bit wider so ptr + offset cannot overflow before the wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]     ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [SUM_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int o = 0; o < NUM_PORTS - 1; o++) begin
      idx = SUM_W'(ptr) + SUM_W'(o);
      if (idx >= SUM_W'(NUM_PORTS)) idx = idx - SUM_W'(NUM_PORTS - 1);
      if (!found && req[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign others_req = |port_req[NUM_PORTS-1:1];
  assign p0_wins    = port_req[PORT_PROG] &&
                      !((starve_q == CNT_W'(STARVE_MAX)) && others_req);
  assign winner     = p0_wins ? IDX_W'(PORT_PROG) : rr_pick(port_req, rr_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // Download only takes over once every pending read has returned, so read
  // data never gets interleaved with the download traffic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (download && fifo_empty)                          state_d = DL;
        else if (!download && (|port_req) && !fifo_full)     state_d = ISSUE;
      end
      ISSUE:   if (sdram_ack) state_d = IDLE;
      DL:      if (!download) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sdram_req  = 1'b0;
    sdram_we   = 1'b0;
    sdram_addr = '0;
    port_ack   = '0;
    case (state_q)
      ISSUE: begin
        sdram_req  = 1'b1;
        sdram_addr = addr_q;
        if (sdram_ack) port_ack[grant_q] = 1'b1;
      end
      DL: begin
        sdram_req  = download_req;
        sdram_we   = download_we;
        sdram_addr = download_addr;
      end
      default: ;
    endcase
  end

  assign sdram_data = download_data;

  // ---------------- arbitration bookkeeping ----------------
  assign take = (state_q == IDLE) && (state_d == ISSUE);

  always_comb begin
    grant_d      = grant_q;
    addr_d       = addr_q;
    rr_d         = rr_q;
    starve_d     = starve_q;
    err_orphan_d = err_orphan_q | (sdram_valid & fifo_empty);
    if (take) begin
      grant_d = winner;
      addr_d  = port_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      if (winner != IDX_W'(PORT_PROG)) begin
        rr_d     = (winner == IDX_W'(NUM_PORTS - 1)) ? IDX_W'(1) : winner + IDX_W'(1);
        starve_d = '0;
      end else if (others_req) begin
        if (starve_q != CNT_W'(STARVE_MAX)) starve_d = starve_q + CNT_W'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q      <= '0;
      addr_q       <= '0;
      rr_q         <= IDX_W'(1);
      starve_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      rr_q         <= rr_d;
      starve_q     <= starve_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign err_orphan = err_orphan_q;

  // ---------------- read return routing ----------------
  assign fifo_push = (state_q == ISSUE) && sdram_ack;
  assign fifo_pop  = sdram_valid && !fifo_empty;

  grant_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (IDX_W)
  ) u_grant_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (grant_q),
    .pop_i   (fifo_pop),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .head_o  (fifo_head)
  );

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
    assign port_valid[gi] = fifo_pop && (fifo_head == IDX_W'(gi));
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;
  import rom_ctrl_pkg::*;

  localparam int NP = 6;
  localparam int AW = 23;
  localparam int SM = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     port_req;
  logic [NP*AW-1:0]  port_addr;
  logic [NP-1:0]     port_ack, port_valid;
  logic              download, download_req, download_we;
  logic [AW-1:0]     download_addr;
  logic [31:0]       download_data;
  logic [AW-1:0]     sdram_addr;
  logic [31:0]       sdram_data;
  logic              sdram_we, sdram_req, sdram_ack, sdram_valid, err_orphan;

  int total = 0;
  int bad   = 0;

  // Reference model: round-robin position, starvation count, addresses,
  // and the expected order in which read data must come back.
  int          m_rr, m_starve;
  logic [AW-1:0] m_addr [NP];
  int          exp_q[$];
  int          got_q[$];

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .MAX_PENDING(4), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .port_req(port_req), .port_addr(port_addr),
    .port_ack(port_ack), .port_valid(port_valid),
    .download(download), .download_req(download_req), .download_we(download_we),
    .download_addr(download_addr), .download_data(download_data),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Who should win next, given the requesting set; updates the model state.
  function automatic int model_grant(input logic [NP-1:0] req);
    int w;
    bit others;
    others = |req[NP-1:1];
    w = -1;
    if (req[0] && !(m_starve == SM && others)) w = 0;
    else begin
      for (int o = 0; o < NP - 1; o++) begin
        int p;
        p = 1 + (m_rr - 1 + o) % (NP - 1);
        if (w < 0 && req[p]) w = p;
      end
    end
    if (w > 0) begin
      m_rr = (w % (NP - 1)) + 1;
      m_starve = 0;
    end else if (w == 0) begin
      m_starve = others ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
    end
    return w;
  endfunction

  task automatic set_addr(input int p);
    m_addr[p] = AW'($urandom);
    port_addr[p*AW +: AW] = m_addr[p];
  endtask

  task automatic apply_reset();
    port_req = '0; sdram_ack = 0; sdram_valid = 0;
    download = 0; download_req = 0; download_we = 0;
    download_addr = '0; download_data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_rr = 1; m_starve = 0;
    exp_q.delete(); got_q.delete();
    for (int p = 0; p < NP; p++) set_addr(p);
  endtask

  // Pulse sdram_valid until every expected read has been returned.
  task automatic drain();
    logic [NP-1:0] expv;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      sdram_ack = 0; sdram_valid = 1; #1;
      expv = onehot(exp_q.pop_front());
      total++;
      if (port_valid !== expv) begin bad++; $display("FAIL drain_valid got=%b want=%b", port_valid, expv); end
    end
    @(negedge clk);
    sdram_valid = 0;
  endtask

  // Accept every request immediately until n acks (or max_cyc cycles).
  task automatic issue_n(input logic [NP-1:0] mask, input int n, input int max_cyc, output int acks);
    int w;
    acks = 0;
    port_req = mask;
    for (int c = 0; c < max_cyc && acks < n; c++) begin
      @(negedge clk);
      sdram_ack = 0; sdram_valid = 0; #1;
      if (sdram_req) begin
        w = model_grant(mask);
        total++;
        if (sdram_addr !== m_addr[w]) begin bad++; $display("FAIL issue_addr got=%h want=%h", sdram_addr, m_addr[w]); end
        sdram_ack = 1; #1;
        total++;
        if (port_ack !== onehot(w)) begin bad++; $display("FAIL issue_ack got=%b want=%b", port_ack, onehot(w)); end
        exp_q.push_back(w);
        acks++;
      end
    end
    port_req = '0;
  endtask

  // Constant request set, random ack latency, random read returns.
  task automatic run_traffic(input logic [NP-1:0] mask, input int n, input int dly_max, input int vpct);
    int grants, cyc, wait_cnt, dly, w, upd;
    bit in_issue;
    logic [NP-1:0] expv;
    grants = 0; cyc = 0; in_issue = 0; upd = -1; w = 0; wait_cnt = 0; dly = 0;
    got_q.delete();
    port_req = mask;
    while (grants < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      sdram_ack = 0;
      if (upd >= 0) begin set_addr(upd); upd = -1; end
      sdram_valid = (exp_q.size() > 0) && ($urandom_range(99) < vpct);
      #1;
      expv = sdram_valid ? onehot(exp_q.pop_front()) : '0;
      total++;
      if (port_valid !== expv) begin bad++; $display("FAIL traffic_valid got=%b want=%b", port_valid, expv); end
      if (sdram_req) begin
        if (!in_issue) begin
          in_issue = 1; w = model_grant(mask); wait_cnt = 0; dly = $urandom_range(dly_max);
        end
        total++;
        if (sdram_addr !== m_addr[w] || sdram_we !== 1'b0) begin
          bad++; $display("FAIL traffic_addr port=%0d got=%h we=%b want=%h", w, sdram_addr, sdram_we, m_addr[w]);
        end
        if (wait_cnt == dly) begin
          sdram_ack = 1; #1;
          total++;
          if (port_ack !== onehot(w)) begin bad++; $display("FAIL traffic_ack got=%b want=%b", port_ack, onehot(w)); end
          exp_q.push_back(w); got_q.push_back(w);
          grants++; in_issue = 0; upd = w;
        end else wait_cnt++;
      end
    end
    total++;
    if (grants < n) begin bad++; $display("FAIL traffic_timeout got=%0d grants want=%0d", grants, n); end
    @(negedge clk);
    sdram_ack = 0; sdram_valid = 0; port_req = '0;
    if (upd >= 0) set_addr(upd);
    drain();
  endtask

  task automatic test_reset();
    reset = 1'b1; port_req = '1; download_data = 32'hA5A5_1234; sdram_valid = 1;
    @(negedge clk); #1;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", sdram_req); end
    total++; if (port_ack !== '0 || port_valid !== '0) begin bad++; $display("FAIL reset_pulses ack=%b valid=%b want=0", port_ack, port_valid); end
    total++; if (sdram_addr !== '0 || sdram_we !== 1'b0) begin bad++; $display("FAIL reset_addr_we addr=%h we=%b want=0", sdram_addr, sdram_we); end
    total++; if (sdram_data !== 32'hA5A5_1234) begin bad++; $display("FAIL reset_data got=%h want=a5a51234", sdram_data); end
    total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_orphan got=%b want=0", err_orphan); end
    apply_reset();
  endtask

  task automatic test_single();
    int ack_c[NP], val_c[NP];
    int req_cycles;
    bit req_first;
    apply_reset();
    req_cycles = 0; req_first = 0;
    for (int p = 0; p < NP; p++) begin ack_c[p] = 0; val_c[p] = 0; end
    m_addr[PORT_FG] = 23'h040010;
    port_addr[PORT_FG*AW +: AW] = 23'h040010;
    port_req = onehot(PORT_FG);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sdram_ack = 0;
      sdram_valid = (c == 4);
      if (c == 3) port_req = '0;
      #1;
      if (c == 0) req_first = sdram_req;
      if (sdram_req) begin
        req_cycles++;
        total++;
        if (sdram_addr !== 23'h040010) begin bad++; $display("FAIL single_addr got=%h want=040010", sdram_addr); end
      end
      if (c == 2) begin sdram_ack = 1; #1; end
      for (int p = 0; p < NP; p++) begin
        ack_c[p] += int'(port_ack[p]);
        val_c[p] += int'(port_valid[p]);
      end
    end
    sdram_valid = 0; sdram_ack = 0;
    total++; if (req_first !== 1'b1) begin bad++; $display("FAIL single_req_first got=%b want=1", req_first); end
    total++; if (req_cycles != 3) begin bad++; $display("FAIL single_req_cycles got=%0d want=3", req_cycles); end
    for (int p = 0; p < NP; p++) begin
      total++;
      if (ack_c[p] != ((p == PORT_FG) ? 1 : 0) || val_c[p] != ((p == PORT_FG) ? 1 : 0)) begin
        bad++; $display("FAIL single_pulses port=%0d acks=%0d valids=%0d", p, ack_c[p], val_c[p]);
      end
    end
  endtask

  task automatic test_round_robin();
    int want[6];
    want = '{1, 3, 4, 1, 3, 4};
    apply_reset();
    run_traffic(onehot(PORT_TEXT) | onehot(PORT_BG) | onehot(PORT_SPRITE), 6, 2, 60);
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL rr_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] != want[i]) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_starvation();
    int want[8];
    want = '{0, 0, 0, 5, 0, 0, 0, 5};
    apply_reset();
    run_traffic(onehot(PORT_PROG) | onehot(PORT_SOUND), 8, 2, 60);
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL starve_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] != want[i]) begin bad++; $display("FAIL starve_order[%0d] got=%0d want=%0d", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_fifo_full();
    logic [NP-1:0] mask, expv;
    int acks, w;
    bit seen;
    apply_reset();
    mask = NP'($urandom_range(1, 63));
    issue_n(mask, 5, 20, acks);
    total++; if (acks != 4) begin bad++; $display("FAIL full_acks got=%0d want=4", acks); end
    port_req = mask;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sdram_ack = 0; #1;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL full_stall cycle=%0d got=%b want=0", c, sdram_req); end
    end
    @(negedge clk);
    sdram_valid = 1; #1;
    expv = onehot(exp_q.pop_front());
    total++; if (port_valid !== expv) begin bad++; $display("FAIL full_valid got=%b want=%b", port_valid, expv); end
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      sdram_valid = 0; sdram_ack = 0; #1;
      if (sdram_req) begin
        seen = 1;
        w = model_grant(mask);
        total++; if (sdram_addr !== m_addr[w]) begin bad++; $display("FAIL full_fifth_addr got=%h want=%h", sdram_addr, m_addr[w]); end
        sdram_ack = 1; #1;
        total++; if (port_ack !== onehot(w)) begin bad++; $display("FAIL full_fifth_ack got=%b want=%b", port_ack, onehot(w)); end
        exp_q.push_back(w);
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL full_fifth_timeout got=no request want=request"); end
    @(negedge clk);
    sdram_ack = 0; port_req = '0;
    drain();
  endtask

  task automatic test_download();
    int acks, w;
    bit seen;
    logic [NP-1:0] expv;
    apply_reset();
    issue_n(onehot(PORT_TEXT) | onehot(PORT_FG), 2, 20, acks);
    total++; if (acks != 2) begin bad++; $display("FAIL dl_setup_acks got=%0d want=2", acks); end
    download = 1; download_req = 1; download_we = 1;
    download_addr = AW'($urandom); download_data = $urandom;
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        sdram_ack = 0; sdram_valid = 0; #1;
        total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL dl_early pending=%0d got=%b want=0", 2 - v, sdram_req); end
      end
      @(negedge clk);
      sdram_valid = 1; #1;
      expv = onehot(exp_q.pop_front());
      total++; if (port_valid !== expv) begin bad++; $display("FAIL dl_valid got=%b want=%b", port_valid, expv); end
    end
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      sdram_valid = 0; #1;
      seen = sdram_req;
    end
    total++; if (!seen) begin bad++; $display("FAIL dl_enter_timeout got=no request want=request"); end
    total++;
    if (sdram_we !== 1'b1 || sdram_addr !== download_addr || sdram_data !== download_data) begin
      bad++; $display("FAIL dl_pass we=%b addr=%h data=%h want we=1 addr=%h data=%h", sdram_we, sdram_addr, sdram_data, download_addr, download_data);
    end
    @(negedge clk);
    download_we = 0; download_addr = AW'($urandom); sdram_ack = 1; #1;
    total++;
    if (sdram_req !== 1'b1 || sdram_we !== 1'b0 || sdram_addr !== download_addr || port_ack !== '0) begin
      bad++; $display("FAIL dl_pass2 req=%b we=%b addr=%h ack=%b want 1/0/%h/0", sdram_req, sdram_we, sdram_addr, port_ack, download_addr);
    end
    @(negedge clk);
    download_req = 0; sdram_ack = 0; #1;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL dl_req_follow got=%b want=0", sdram_req); end
    @(negedge clk);
    download = 0; port_req = onehot(PORT_BG);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      sdram_ack = 0; #1;
      if (sdram_req) begin
        seen = 1;
        w = model_grant(onehot(PORT_BG));
        total++;
        if (sdram_we !== 1'b0 || sdram_addr !== m_addr[w]) begin bad++; $display("FAIL dl_resume_addr we=%b got=%h want=%h", sdram_we, sdram_addr, m_addr[w]); end
        sdram_ack = 1; #1;
        total++; if (port_ack !== onehot(w)) begin bad++; $display("FAIL dl_resume_ack got=%b want=%b", port_ack, onehot(w)); end
        exp_q.push_back(w);
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL dl_resume_timeout got=no request want=request"); end
    @(negedge clk);
    sdram_ack = 0; port_req = '0;
    drain();
  endtask

  task automatic test_random();
    apply_reset();
    for (int it = 0; it < 4; it++) begin
      run_traffic(NP'($urandom_range(1, 63)), 10, 3, 35);
    end
  endtask

  task automatic test_orphan();
    int acks;
    apply_reset();
    issue_n(onehot(PORT_FG) | onehot(PORT_SPRITE), 2, 20, acks);
    total++; if (acks != 2) begin bad++; $display("FAIL orphan_setup_acks got=%0d want=2", acks); end
    @(negedge clk);
    sdram_ack = 0; reset = 1; #1;
    total++; if (sdram_req !== 1'b0 || port_ack !== '0) begin bad++; $display("FAIL orphan_in_reset req=%b ack=%b want 0", sdram_req, port_ack); end
    @(negedge clk);
    reset = 0; exp_q.delete(); m_rr = 1; m_starve = 0; #1;
    total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_pre got=%b want=0", err_orphan); end
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      sdram_valid = 1; #1;
      total++; if (port_valid !== '0) begin bad++; $display("FAIL orphan_valid got=%b want=0", port_valid); end
      @(negedge clk);
      sdram_valid = 0; #1;
      total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_flag pulse=%0d got=%b want=1", v, err_orphan); end
    end
    repeat (3) @(negedge clk);
    #1;
    total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky got=%b want=1", err_orphan); end
  endtask

  initial begin
    reset = 1'b1;
    port_req = '0; port_addr = '0;
    sdram_ack = 0; sdram_valid = 0;
    download = 0; download_req = 0; download_we = 0;
    download_addr = '0; download_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_fifo_full();
    test_download();
    test_random();
    test_orphan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
